sprint2_audio_post: RTL and testbench

Audio post-processing stage directly downstream of the Sprint 2 core's two 7-bit unsigned sound outputs (`Audio1_O`, `Audio2_O`). It sits between the core and the top-level `AUDIO_L` / `AUDIO_R` pins.

The block decimates the outputs to a fixed sample rate and re-centres them to signed 16-bit. An optional first-order DC-blocking high-pass removes the offset, and the result is saturated. Both channels are processed by a small time-multiplexed FSM that shares one arithmetic path.

---
 rtl/sprint2_audio_pkg.sv | 39 +++
 rtl/sprint2_audio_dcstage.sv | 30 +++
 rtl/sprint2_audio_post.sv | 154 +++++++++++++++
 tb/tb_sprint2_audio_post.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprint2_audio_pkg.sv
// sprint2_audio_pkg: shared types, widths and helpers for the Sprint 2 audio
// post-processing stage (sprint2_audio_post / sprint2_audio_dcstage).
package sprint2_audio_pkg;

   localparam int unsigned AUD_IN_W    = 7;    // core sound output width
   localparam int unsigned AUD_X_W     = 17;   // centred sample width
   localparam int unsigned AUD_ACC_W   = 19;   // filter accumulator width
   localparam int unsigned AUD_OUT_W   = 16;   // signed output sample width
   localparam int unsigned AUD_MID     = 64;   // input code mapped to zero
   localparam int unsigned AUD_X_SHIFT = 9;    // scales 7-bit codes to 16-bit range

   localparam logic signed [AUD_ACC_W-1:0] ACC_MAX = 19'sd32767;
   localparam logic signed [AUD_ACC_W-1:0] ACC_MIN = -19'sd32768;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CH_L   = 2'd1,
      CH_R   = 2'd2,
      COMMIT = 2'd3
   } aud_state_t;

   // Clamp an accumulator value to the signed 16-bit output range.
   function automatic logic signed [AUD_OUT_W-1:0] sat16(input logic signed [AUD_ACC_W-1:0] v);
      if (v > ACC_MAX)
         return 16'sh7FFF;
      else if (v < ACC_MIN)
         return 16'sh8000;
      else
         return v[AUD_OUT_W-1:0];
   endfunction

   // Re-centre an unsigned core code: x = ({1'b0,a} - 64) << 9.
   function automatic logic signed [AUD_X_W-1:0] aud_centre(input logic [AUD_IN_W-1:0] a);
      logic signed [AUD_IN_W:0] d;
      d = $signed({1'b0, a}) - $signed((AUD_IN_W+1)'(AUD_MID));
      return AUD_X_W'(d) <<< AUD_X_SHIFT;
   endfunction

endpackage

// File: rtl/sprint2_audio_dcstage.sv
// sprint2_audio_dcstage: combinational first-order DC-blocker step shared by
// both channels. y = sat16(x - x_prev + y_prev - (y_prev >>> DC_SHIFT)).
// Ports:
//   x       in  17  current centred sample
//   x_prev  in  17  previous centred sample of the channel
//   y_prev  in  16  previous filter output of the channel
//   y       out 16  saturated filter output
// With x_prev = y_prev = 0 the stage reduces to sat16(x).
module sprint2_audio_dcstage
   import sprint2_audio_pkg::*;
#(
   parameter int unsigned DC_SHIFT = 8
) (
   input  logic signed [AUD_X_W-1:0]   x,
   input  logic signed [AUD_X_W-1:0]   x_prev,
   input  logic signed [AUD_OUT_W-1:0] y_prev,
   output logic signed [AUD_OUT_W-1:0] y
);

   logic signed [AUD_ACC_W-1:0] acc;

   // Arithmetic shift floors toward -inf; the small residual is accepted.
   always_comb begin
      acc = AUD_ACC_W'(x) - AUD_ACC_W'(x_prev) + AUD_ACC_W'(y_prev)
          - AUD_ACC_W'(y_prev >>> DC_SHIFT);
   end

   assign y = sat16(acc);

endmodule

// File: rtl/sprint2_audio_post.sv
// sprint2_audio_post: decimates the Sprint 2 core's two 7-bit sound outputs to
// one stereo sample every CLK_DIV cycles, re-centres them to signed 16-bit and
// optionally DC-blocks them, using one arithmetic stage time-shared by a
// four-state FSM (IDLE -> CH_L -> CH_R -> COMMIT).
// Ports:
//   clk_sys      in  1   system clock (core clk_12)
//   reset_n      in  1   asynchronous active-low reset
//   audio1_i     in  7   core channel 1, unsigned
//   audio2_i     in  7   core channel 2, unsigned
//   mute_i       in  1   forces centred input to 0, sampled on tick
//   audio_l_o    out 16  signed left sample (channel 1)
//   audio_r_o    out 16  signed right sample (channel 2)
//   sample_stb_o out 1   one-cycle pulse when the outputs update
// Macro SPRINT2_AUDIO_DCBLOCK_EN: defined builds the DC-blocker state;
// undefined runs the stage with zero state, i.e. y = sat16(x).
module sprint2_audio_post
   import sprint2_audio_pkg::*;
#(
   parameter int unsigned CLK_DIV  = 250,
   parameter int unsigned DC_SHIFT = 8
) (
   input  logic                        clk_sys,
   input  logic                        reset_n,
   input  logic [AUD_IN_W-1:0]         audio1_i,
   input  logic [AUD_IN_W-1:0]         audio2_i,
   input  logic                        mute_i,
   output logic signed [AUD_OUT_W-1:0] audio_l_o,
   output logic signed [AUD_OUT_W-1:0] audio_r_o,
   output logic                        sample_stb_o
);

   localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [DIV_W-1:0]            div_cnt;
   logic                        tick;
   logic signed [AUD_X_W-1:0]   x_l_q, x_r_q;
   aud_state_t                  state, state_nxt;
   logic                        ld_l_c, ld_r_c, commit_c;
   logic                        ch_r_sel;
   logic signed [AUD_X_W-1:0]   dc_x, dc_xp;
   logic signed [AUD_OUT_W-1:0] dc_yp, dc_y;
   logic signed [AUD_OUT_W-1:0] y_l_q, y_r_q;

   // Sample-rate prescaler.
   assign tick = (div_cnt == DIV_W'(CLK_DIV - 1));

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n)
         div_cnt <= '0;
      else if (tick)
         div_cnt <= '0;
      else
         div_cnt <= div_cnt + DIV_W'(1);
   end

   // Both channels and mute captured on the same tick so L/R stay coherent.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         x_l_q <= '0;
         x_r_q <= '0;
      end else if (tick) begin
         x_l_q <= mute_i ? '0 : aud_centre(audio1_i);
         x_r_q <= mute_i ? '0 : aud_centre(audio2_i);
      end
   end

   // FSM state register.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // FSM next state and datapath load enables.
   always_comb begin
      state_nxt = state;
      ld_l_c    = 1'b0;
      ld_r_c    = 1'b0;
      commit_c  = 1'b0;
      case (state)
         IDLE:    if (tick) state_nxt = CH_L;
         CH_L:    begin ld_l_c   = 1'b1; state_nxt = CH_R;   end
         CH_R:    begin ld_r_c   = 1'b1; state_nxt = COMMIT; end
         COMMIT:  begin commit_c = 1'b1; state_nxt = IDLE;   end
         default: state_nxt = IDLE;
      endcase
   end

   // Per-channel operand mux into the shared stage.
   assign ch_r_sel = (state == CH_R);
   assign dc_x     = ch_r_sel ? x_r_q : x_l_q;

`ifdef SPRINT2_AUDIO_DCBLOCK_EN
   logic signed [AUD_X_W-1:0]   xp_l_q, xp_r_q;
   logic signed [AUD_OUT_W-1:0] yp_l_q, yp_r_q;

   // Filter history, updated as each channel is computed.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         xp_l_q <= '0;
         yp_l_q <= '0;
         xp_r_q <= '0;
         yp_r_q <= '0;
      end else begin
         if (ld_l_c) begin
            xp_l_q <= x_l_q;
            yp_l_q <= dc_y;
         end
         if (ld_r_c) begin
            xp_r_q <= x_r_q;
            yp_r_q <= dc_y;
         end
      end
   end

   assign dc_xp = ch_r_sel ? xp_r_q : xp_l_q;
   assign dc_yp = ch_r_sel ? yp_r_q : yp_l_q;
`else
   assign dc_xp = '0;
   assign dc_yp = '0;
`endif

   sprint2_audio_dcstage #(
      .DC_SHIFT (DC_SHIFT)
   ) u_dcstage (
      .x      (dc_x),
      .x_prev (dc_xp),
      .y_prev (dc_yp),
      .y      (dc_y)
   );

   // Staging and output registers; both outputs change together on commit.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         y_l_q        <= '0;
         y_r_q        <= '0;
         audio_l_o    <= '0;
         audio_r_o    <= '0;
         sample_stb_o <= 1'b0;
      end else begin
         if (ld_l_c)
            y_l_q <= dc_y;
         if (ld_r_c)
            y_r_q <= dc_y;
         if (commit_c) begin
            audio_l_o <= y_l_q;
            audio_r_o <= y_r_q;
         end
         sample_stb_o <= commit_c;
      end
   end

endmodule

// File: tb/tb_sprint2_audio_post.sv
// tb_sprint2_audio_post: directed self-checking bench for sprint2_audio_post.
// Expected values follow the build: SPRINT2_AUDIO_DCBLOCK_EN selects the
// DC-blocker expectations, otherwise bypass expectations are used.
module tb_sprint2_audio_post;
   import sprint2_audio_pkg::*;

   localparam int unsigned TB_DIV = 16;

   logic               clk_sys;
   logic               reset_n;
   logic [6:0]         audio1_i;
   logic [6:0]         audio2_i;
   logic               mute_i;
   logic signed [15:0] audio_l_o;
   logic signed [15:0] audio_r_o;
   logic               sample_stb_o;

   int tests_run;
   int tests_failed;

   sprint2_audio_post #(
      .CLK_DIV  (TB_DIV),
      .DC_SHIFT (8)
   ) dut (
      .clk_sys      (clk_sys),
      .reset_n      (reset_n),
      .audio1_i     (audio1_i),
      .audio2_i     (audio2_i),
      .mute_i       (mute_i),
      .audio_l_o    (audio_l_o),
      .audio_r_o    (audio_r_o),
      .sample_stb_o (sample_stb_o)
   );

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Waits for the next strobe, counting posedges; timeout counts as a failure.
   task automatic wait_stb(input int limit, output int n);
      bit ok;
      n  = 0;
      ok = 1'b0;
      while (n < limit) begin
         @(posedge clk_sys);
         #1;
         n++;
         if (sample_stb_o) begin
            ok = 1'b1;
            break;
         end
      end
      tests_run++;
      if (!ok) begin
         tests_failed++;
         $display("FAIL stb_timeout: no strobe within %0d cycles", limit);
      end
   endtask

   task automatic do_reset();
      @(negedge clk_sys);
      reset_n = 1'b0;
      repeat (3) @(negedge clk_sys);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      reset_n  = 1'b0;
      audio1_i = 7'd127;
      audio2_i = 7'd0;
      mute_i   = 1'b0;
      repeat (3) @(negedge clk_sys);
      tests_run++;
      if (audio_l_o !== 16'sd0) begin
         tests_failed++;
         $display("FAIL reset_l: got %0d want 0", audio_l_o);
      end
      tests_run++;
      if (audio_r_o !== 16'sd0) begin
         tests_failed++;
         $display("FAIL reset_r: got %0d want 0", audio_r_o);
      end
      tests_run++;
      if (sample_stb_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_stb: got %b want 0", sample_stb_o);
      end
      reset_n = 1'b1;
   endtask

   task automatic test_first_sample();
      int n;
      wait_stb(TB_DIV + 10, n);
      tests_run++;
      if (n != TB_DIV + 3) begin
         tests_failed++;
         $display("FAIL first_latency: got %0d want %0d", n, TB_DIV + 3);
      end
      tests_run++;
      if (audio_l_o !== 16'(32256)) begin
         tests_failed++;
         $display("FAIL first_l: got %0d want 32256", audio_l_o);
      end
      tests_run++;
      if (audio_r_o !== 16'(-32768)) begin
         tests_failed++;
         $display("FAIL first_r: got %0d want -32768", audio_r_o);
      end
   endtask

   task automatic test_strobe_spacing();
      int n;
      bit stable;
      bit tick_ok;
      bit got;
      logic signed [15:0] e_l, e_r;
      e_l     = 16'(32256);
      e_r     = 16'(-32768);
      stable  = 1'b1;
      tick_ok = 1'b1;
      got     = 1'b0;
      n       = 0;
      @(posedge clk_sys);
      #1;
      n++;
      tests_run++;
      if (sample_stb_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL stb_width: got %b want 0 one cycle after strobe", sample_stb_o);
      end
      while (n < 4 * TB_DIV) begin
         if (dut.tick && (dut.state !== IDLE)) tick_ok = 1'b0;
         if (sample_stb_o) begin
            got = 1'b1;
            break;
         end
         if ((audio_l_o !== e_l) || (audio_r_o !== e_r)) stable = 1'b0;
         @(posedge clk_sys);
         #1;
         n++;
      end
      tests_run++;
      if (!got || n != TB_DIV) begin
         tests_failed++;
         $display("FAIL stb_period: got %0d want %0d (strobe seen %b)", n, TB_DIV, got);
      end
      tests_run++;
      if (!stable) begin
         tests_failed++;
         $display("FAIL hold_between_strobes: got changing outputs want %0d/%0d", e_l, e_r);
      end
      tests_run++;
      if (!tick_ok) begin
         tests_failed++;
         $display("FAIL tick_in_idle: got tick outside IDLE want IDLE only");
      end
`ifdef SPRINT2_AUDIO_DCBLOCK_EN
      e_l = 16'(32130);
      e_r = 16'(-32640);
`endif
      tests_run++;
      if (audio_l_o !== e_l) begin
         tests_failed++;
         $display("FAIL second_l: got %0d want %0d", audio_l_o, e_l);
      end
      tests_run++;
      if (audio_r_o !== e_r) begin
         tests_failed++;
         $display("FAIL second_r: got %0d want %0d", audio_r_o, e_r);
      end
   endtask

`ifndef SPRINT2_AUDIO_DCBLOCK_EN
   task automatic test_boundary_values();
      int n;
      audio1_i = 7'd64;
      audio2_i = 7'd1;
      wait_stb(2 * TB_DIV, n);
      tests_run++;
      if (audio_l_o !== 16'sd0) begin
         tests_failed++;
         $display("FAIL centre_64: got %0d want 0", audio_l_o);
      end
      tests_run++;
      if (audio_r_o !== 16'(-32256)) begin
         tests_failed++;
         $display("FAIL code_1: got %0d want -32256", audio_r_o);
      end
      audio1_i = 7'd63;
      audio2_i = 7'd65;
      wait_stb(2 * TB_DIV, n);
      tests_run++;
      if (audio_l_o !== 16'(-512)) begin
         tests_failed++;
         $display("FAIL code_63: got %0d want -512", audio_l_o);
      end
      tests_run++;
      if (audio_r_o !== 16'(512)) begin
         tests_failed++;
         $display("FAIL code_65: got %0d want 512", audio_r_o);
      end
   endtask
`endif

   task automatic test_mute();
      int n;
      logic signed [15:0] e;
      audio1_i = 7'd127;
      audio2_i = 7'd127;
      mute_i   = 1'b0;
      do_reset();
      wait_stb(TB_DIV + 10, n);
      tests_run++;
      if ((audio_l_o !== 16'(32256)) || (audio_r_o !== 16'(32256))) begin
         tests_failed++;
         $display("FAIL mute_pre: got %0d/%0d want 32256/32256", audio_l_o, audio_r_o);
      end
      // mute pulse between ticks must be ignored
      repeat (2) @(posedge clk_sys);
      #1 mute_i = 1'b1;
      repeat (3) @(posedge clk_sys);
      #1 mute_i = 1'b0;
      wait_stb(2 * TB_DIV, n);
`ifdef SPRINT2_AUDIO_DCBLOCK_EN
      e = 16'(32130);
`else
      e = 16'(32256);
`endif
      tests_run++;
      if ((audio_l_o !== e) || (audio_r_o !== e)) begin
         tests_failed++;
         $display("FAIL mute_glitch_ignored: got %0d/%0d want %0d", audio_l_o, audio_r_o, e);
      end
      mute_i = 1'b1;
      wait_stb(2 * TB_DIV, n);
`ifdef SPRINT2_AUDIO_DCBLOCK_EN
      e = 16'(-251);
`else
      e = 16'sd0;
`endif
      tests_run++;
      if ((audio_l_o !== e) || (audio_r_o !== e)) begin
         tests_failed++;
         $display("FAIL mute_on: got %0d/%0d want %0d", audio_l_o, audio_r_o, e);
      end
      mute_i = 1'b0;
      wait_stb(2 * TB_DIV, n);
`ifdef SPRINT2_AUDIO_DCBLOCK_EN
      e = 16'(32006);
`else
      e = 16'(32256);
`endif
      tests_run++;
      if ((audio_l_o !== e) || (audio_r_o !== e)) begin
         tests_failed++;
         $display("FAIL mute_off: got %0d/%0d want %0d", audio_l_o, audio_r_o, e);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      bit found;
      bit stb_seen;
      audio1_i = 7'd127;
      audio2_i = 7'd0;
      wait_stb(2 * TB_DIV, n);
      found = 1'b0;
      for (int i = 0; i < 2 * TB_DIV; i++) begin
         @(posedge clk_sys);
         #1;
         if (dut.state == CH_R) begin
            found = 1'b1;
            break;
         end
      end
      tests_run++;
      if (!found) begin
         tests_failed++;
         $display("FAIL reach_ch_r: got no CH_R want CH_R within %0d cycles", 2 * TB_DIV);
      end
      reset_n = 1'b0;
      #1;
      tests_run++;
      if ((audio_l_o !== 16'sd0) || (audio_r_o !== 16'sd0)) begin
         tests_failed++;
         $display("FAIL async_reset_out: got %0d/%0d want 0/0", audio_l_o, audio_r_o);
      end
      stb_seen = sample_stb_o;
      repeat (4) begin
         @(negedge clk_sys);
         if (sample_stb_o) stb_seen = 1'b1;
      end
      tests_run++;
      if (stb_seen) begin
         tests_failed++;
         $display("FAIL reset_no_stb: got strobe want none during reset");
      end
      reset_n = 1'b1;
      wait_stb(TB_DIV + 10, n);
      tests_run++;
      if (n != TB_DIV + 3) begin
         tests_failed++;
         $display("FAIL post_reset_latency: got %0d want %0d", n, TB_DIV + 3);
      end
      tests_run++;
      if ((audio_l_o !== 16'(32256)) || (audio_r_o !== 16'(-32768))) begin
         tests_failed++;
         $display("FAIL post_reset_state: got %0d/%0d want 32256/-32768", audio_l_o, audio_r_o);
      end
   endtask

`ifdef SPRINT2_AUDIO_DCBLOCK_EN
   task automatic test_dc_step();
      int n;
      bit mono;
      logic signed [15:0] prev;
      audio1_i = 7'd64;
      audio2_i = 7'd64;
      do_reset();
      wait_stb(TB_DIV + 10, n);
      wait_stb(2 * TB_DIV, n);
      tests_run++;
      if ((audio_l_o !== 16'sd0) || (audio_r_o !== 16'sd0)) begin
         tests_failed++;
         $display("FAIL dc_idle_zero: got %0d/%0d want 0/0", audio_l_o, audio_r_o);
      end
      audio1_i = 7'd127;
      audio2_i = 7'd127;
      wait_stb(2 * TB_DIV, n);
      tests_run++;
      if (audio_l_o !== 16'(32256)) begin
         tests_failed++;
         $display("FAIL dc_step_0: got %0d want 32256", audio_l_o);
      end
      wait_stb(2 * TB_DIV, n);
      tests_run++;
      if (audio_l_o !== 16'(32130)) begin
         tests_failed++;
         $display("FAIL dc_step_1: got %0d want 32130", audio_l_o);
      end
      wait_stb(2 * TB_DIV, n);
      tests_run++;
      if (audio_r_o !== 16'(32005)) begin
         tests_failed++;
         $display("FAIL dc_step_2: got %0d want 32005", audio_r_o);
      end
      mono = 1'b1;
      prev = 16'(32005);
      for (int i = 0; i < 20; i++) begin
         wait_stb(2 * TB_DIV, n);
         if ((audio_l_o >= prev) || (audio_l_o < 16'sd0)) mono = 1'b0;
         prev = audio_l_o;
      end
      tests_run++;
      if (!mono) begin
         tests_failed++;
         $display("FAIL dc_decay: got non-monotonic decay, last %0d want decreasing >= 0", prev);
      end
   endtask

   task automatic test_dc_saturate();
      int n;
      audio1_i = 7'd0;
      audio2_i = 7'd0;
      do_reset();
      wait_stb(TB_DIV + 10, n);
      for (int i = 0; i < 2000; i++) wait_stb(2 * TB_DIV, n);
      tests_run++;
      if (audio_l_o !== 16'sd0) begin
         tests_failed++;
         $display("FAIL dc_settled: got %0d want 0", audio_l_o);
      end
      audio1_i = 7'd127;
      wait_stb(2 * TB_DIV, n);
      tests_run++;
      if (audio_l_o !== 16'sh7FFF) begin
         tests_failed++;
         $display("FAIL dc_sat_pos: got %0d want 32767", audio_l_o);
      end
      tests_run++;
      if (audio_r_o !== 16'sd0) begin
         tests_failed++;
         $display("FAIL dc_sat_other_ch: got %0d want 0", audio_r_o);
      end
      wait_stb(2 * TB_DIV, n);
      tests_run++;
      if (audio_l_o !== 16'(32640)) begin
         tests_failed++;
         $display("FAIL dc_sat_yprev: got %0d want 32640", audio_l_o);
      end
   endtask
`endif

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      test_reset();
      test_first_sample();
      test_strobe_spacing();
`ifndef SPRINT2_AUDIO_DCBLOCK_EN
      test_boundary_values();
`endif
      test_mute();
      test_reset_mid();
`ifdef SPRINT2_AUDIO_DCBLOCK_EN
      test_dc_step();
      test_dc_saturate();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
